// File: rtl/inverter_test_sequencer.sv
// Inverter / buffer loopback tester.
// Toggles stim_out, waits for the device under test to echo the expected
// level on resp_in (seen through a 2-flop synchroniser), measures the echo
// latency in clk cycles and tallies passing and failing trials over a run.
module inverter_test_sequencer #(
  parameter int NUM_TRIALS = 16,  // stimulus edges per run, 1..255
  parameter int TIMEOUT    = 200, // max WAIT cycles per trial, 3..255
  parameter int SETTLE     = 4,   // idle cycles between trials, 1..255
  parameter int INVERT     = 0    // 1: device under test inverts
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       resp_in,
  output logic       stim_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic [7:0] last_lat,
  output logic [7:0] max_lat
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    GAP   = 3'd3,
    FIN   = 3'd4
  } state_e;

  localparam logic [7:0] TRIALS_L    = 8'(NUM_TRIALS);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);
  localparam logic [7:0] TMO_VAL     = 8'(TIMEOUT);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic       INV_BIT     = (INVERT != 0);
  // Latencies below this are a stuck or shorted output, not a real echo.
  localparam logic [7:0] MIN_LAT     = 8'd2;

  state_e     state_q, state_d;
  logic       sync1_q, sync2_q;
  logic       resp_s;
  logic       stim_q, stim_d;
  logic       exp_q, exp_d;
  logic [7:0] lat_q, lat_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] trial_q, trial_d;
  logic [7:0] pass_q, pass_d;
  logic [7:0] fail_q, fail_d;
  logic [7:0] last_q, last_d;
  logic [7:0] max_q, max_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Two-flop synchroniser bringing the asynchronous response into clk.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= resp_in;
      sync2_q <= sync1_q;
    end
  end

  assign resp_s = sync2_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stim_q  <= 1'b0;
      exp_q   <= 1'b0;
      lat_q   <= 8'd0;
      gap_q   <= 8'd0;
      trial_q <= 8'd0;
      pass_q  <= 8'd0;
      fail_q  <= 8'd0;
      last_q  <= 8'd0;
      max_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      exp_q   <= exp_d;
      lat_q   <= lat_d;
      gap_q   <= gap_d;
      trial_q <= trial_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      last_q  <= last_d;
      max_q   <= max_d;
    end
  end

  // Next-state and datapath updates for each FSM state.
  always_comb begin
    // NOTE: every signal gets a hold default first so no latch is inferred.
    state_d = state_q;
    stim_d  = stim_q;
    exp_d   = exp_q;
    lat_d   = lat_q;
    gap_d   = gap_q;
    trial_d = trial_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    last_d  = last_q;
    max_d   = max_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pass_d  = 8'd0;
          fail_d  = 8'd0;
          last_d  = 8'd0;
          max_d   = 8'd0;
          trial_d = 8'd0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        stim_d  = ~stim_q;
        exp_d   = ~stim_q ^ INV_BIT;
        lat_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // A match wins over a timeout landing in the same cycle.
        if (resp_s == exp_q) begin
          last_d = lat_q;
          if (lat_q >= MIN_LAT) begin
            pass_d = sat_inc(pass_q);
            if (lat_q > max_q) max_d = lat_q;
          end else begin
            fail_d = sat_inc(fail_q);
          end
          gap_d   = 8'd0;
          state_d = GAP;
        end else if (lat_q == TMO_LAST) begin
          last_d  = TMO_VAL;
          fail_d  = sat_inc(fail_q);
          gap_d   = 8'd0;
          state_d = GAP;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_q == SETTLE_LAST) begin
          trial_d = trial_q + 8'd1;
          state_d = ((trial_q + 8'd1) < TRIALS_L) ? DRIVE : FIN;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stim_out = stim_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign last_lat = last_q;
  assign max_lat  = max_q;

endmodule

// File: tb/tb_inverter_test_sequencer.sv
// Directed bench for inverter_test_sequencer: loopback models, timeouts,
// mid-run reset, start filtering and a single-trial inverting instance.
module tb_inverter_test_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start1;
  logic       resp_in;
  logic       resp_in1;
  logic       stim_out, stim_out1;
  logic       busy, busy1;
  logic       done, done1;
  logic [7:0] pass_cnt, fail_cnt, last_lat, max_lat;
  logic [7:0] pass_cnt1, fail_cnt1, last_lat1, max_lat1;

  int         mode;        // 0 tied low, 1 direct, 2 five-cycle delay, 3 inverted
  logic [4:0] dly;
  int         checks = 0;
  int         errors = 0;
  int         done_pulses = 0;
  bit         cap_en = 1'b0;
  logic       prev_stim = 1'b0;
  int         lat_log[$];

  always #5 clk = ~clk;

  inverter_test_sequencer #(.NUM_TRIALS(16), .TIMEOUT(200), .SETTLE(4), .INVERT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .resp_in(resp_in),
    .stim_out(stim_out), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .last_lat(last_lat), .max_lat(max_lat)
  );

  inverter_test_sequencer #(.NUM_TRIALS(1), .TIMEOUT(200), .SETTLE(4), .INVERT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .resp_in(resp_in1),
    .stim_out(stim_out1), .busy(busy1), .done(done1),
    .pass_cnt(pass_cnt1), .fail_cnt(fail_cnt1), .last_lat(last_lat1), .max_lat(max_lat1)
  );

  // Device-under-test models.
  always @(posedge clk or posedge rst) begin
    if (rst) dly <= 5'd0;
    else     dly <= {dly[3:0], stim_out};
  end

  always_comb begin
    resp_in = 1'b0;
    case (mode)
      1:       resp_in = stim_out;
      2:       resp_in = dly[4];
      3:       resp_in = ~stim_out;
      default: resp_in = 1'b0;
    endcase
  end

  assign resp_in1 = ~stim_out1;

  // Done pulse counter and last_lat capture at each stimulus edge.
  always @(negedge clk) begin
    if (done) done_pulses++;
    if (cap_en && (stim_out !== prev_stim)) lat_log.push_back(int'(last_lat));
    prev_stim = stim_out;
  end

  // Pulse start (or start1) and count negedges until done is seen.
  task automatic run_and_wait(input bit which, input int budget, output int n, output bit ok);
    @(negedge clk);
    if (which) start1 = 1'b1; else start = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      start  = 1'b0;
      start1 = 1'b0;
      n++;
      if ((which ? done1 : done) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_results(input string tag, input int p, input int f, input int l, input int m);
    checks++;
    if (pass_cnt !== 8'(p) || fail_cnt !== 8'(f) || last_lat !== 8'(l) || max_lat !== 8'(m)) begin
      errors++;
      $display("FAIL %s results got pass=%0d fail=%0d last=%0d max=%0d expected pass=%0d fail=%0d last=%0d max=%0d",
               tag, pass_cnt, fail_cnt, last_lat, max_lat, p, f, l, m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0; mode = 0;
    #1;
    checks++;
    if (stim_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got stim=%b busy=%b done=%b expected 0 0 0", stim_out, busy, done);
    end
    check_results("reset", 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_zero_delay();
    int n; bit ok; int d0;
    mode = 1;
    repeat (4) @(negedge clk);
    d0 = done_pulses;
    run_and_wait(1'b0, 400, n, ok);
    checks++;
    if (!ok || n != 129) begin
      errors++;
      $display("FAIL zero_delay_done_time got ok=%0d cycles=%0d expected ok=1 cycles=129", ok, n);
    end
    check_results("zero_delay", 16, 0, 2, 2);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || (done_pulses - d0) != 1) begin
      errors++;
      $display("FAIL zero_delay_pulse got done=%b busy=%b pulses=%0d expected 0 0 1", done, busy, done_pulses - d0);
    end
  endtask

  task automatic test_delay5();
    int n; bit ok;
    mode = 2;
    repeat (8) @(negedge clk);
    run_and_wait(1'b0, 600, n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL delay5_timeout got no done expected done");
    end
    check_results("delay5", 16, 0, 7, 7);
  endtask

  task automatic test_tied_low();
    int n; bit ok; int bad; int exp_v;
    mode = 0;
    repeat (4) @(negedge clk);
    lat_log.delete();
    cap_en = 1'b1;
    run_and_wait(1'b0, 4000, n, ok);
    cap_en = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tied_low_timeout got no done expected done");
    end
    check_results("tied_low", 0, 16, 0, 0);
    bad = 0;
    for (int j = 0; j < lat_log.size(); j++) begin
      exp_v = (j % 2 == 1) ? 200 : 0;
      if (lat_log[j] != exp_v) bad++;
    end
    checks++;
    if (lat_log.size() != 16 || bad != 0) begin
      errors++;
      $display("FAIL tied_low_alternation got entries=%0d wrong=%0d expected entries=16 wrong=0", lat_log.size(), bad);
    end
  endtask

  task automatic test_inverted_loop();
    int n; bit ok;
    mode = 3;
    repeat (6) @(negedge clk);
    run_and_wait(1'b0, 400, n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL inv_loop_timeout got no done expected done");
    end
    check_results("inv_loop", 0, 16, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    int toggles; int n; bit ok; int d0; logic ps;
    mode = 1;
    repeat (6) @(negedge clk);
    d0 = done_pulses;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    toggles = 0;
    ps = stim_out;
    n = 0;
    while (toggles < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (stim_out !== ps) toggles++;
      ps = stim_out;
    end
    checks++;
    if (toggles != 5 || pass_cnt !== 8'd4) begin
      errors++;
      $display("FAIL mid_run_reach_trial5 got toggles=%0d pass=%0d expected 5 4", toggles, pass_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (stim_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset_ctrl got stim=%b busy=%b done=%b expected 0 0 0", stim_out, busy, done);
    end
    check_results("mid_run_reset", 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (done_pulses != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_no_done got pulses=%0d busy=%b expected 0 0", done_pulses - d0, busy);
    end
    run_and_wait(1'b0, 400, n, ok);
    checks++;
    if (!ok || n != 129) begin
      errors++;
      $display("FAIL clean_rerun_time got ok=%0d cycles=%0d expected ok=1 cycles=129", ok, n);
    end
    check_results("clean_rerun", 16, 0, 2, 2);
  endtask

  task automatic test_start_held();
    int d0; int n; bit busy_ok;
    mode = 1;
    repeat (4) @(negedge clk);
    d0 = done_pulses;
    busy_ok = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    n = 0;
    while (done_pulses == d0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    checks++;
    if (!busy_ok || (done_pulses - d0) != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_held got busy_during=%0d pulses=%0d busy_after=%b expected 1 1 0",
               busy_ok, done_pulses - d0, busy);
    end
    check_results("start_held", 16, 0, 2, 2);
  endtask

  task automatic test_single_trial();
    int n; bit ok;
    run_and_wait(1'b1, 100, n, ok);
    checks++;
    if (!ok || n != 9) begin
      errors++;
      $display("FAIL single_trial_time got ok=%0d cycles=%0d expected ok=1 cycles=9", ok, n);
    end
    checks++;
    if (pass_cnt1 !== 8'd1 || fail_cnt1 !== 8'd0 || last_lat1 !== 8'd2 || max_lat1 !== 8'd2 || stim_out1 !== 1'b1) begin
      errors++;
      $display("FAIL single_trial_results got pass=%0d fail=%0d last=%0d max=%0d stim=%b expected 1 0 2 2 1",
               pass_cnt1, fail_cnt1, last_lat1, max_lat1, stim_out1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL single_trial_pulse got done=%b busy=%b expected 0 0", done1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_zero_delay();
    test_delay5();
    test_tied_low();
    test_inverted_loop();
    test_reset_mid_run();
    test_start_held();
    test_single_trial();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got no completion expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
